// File: rtl/req_pending_latch_pkg.sv
// Shared constants, FSM state encoding and helpers for the request pending latch.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package req_pending_latch_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // One-hot mask selecting the pending bit that a grant index refers to.
   function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] m;
      m = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/req_pending_latch_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for a vector of async request lines.
// Latency: rise_o asserts STAGES clocks after the input edge is first sampled.
// Backpressure: none; one rise pulse per 0->1 level change, held levels pulse once.
//
// Ports:
//   clk     in  1  clock
//   rst     in  1  asynchronous reset, active-high
//   req_i   in  N  raw asynchronous request lines
//   rise_o  out N  single-cycle pulse per synchronized 0->1 transition
module req_pending_latch_sync_edge
   import req_pending_latch_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int N      = N_REQ
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] rise_o
);

   logic [STAGES-1:0][N-1:0] sync_q;
   logic [N-1:0]             dly_q;
   logic [STAGES:0]          arm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         dly_q  <= '0;
         arm_q  <= '0;
      end else begin
         sync_q[0] <= req_i;
         for (int s = 1; s < STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         dly_q <= sync_q[STAGES-1];
         arm_q <= {arm_q[STAGES-1:0], 1'b1};
      end
   end

   // The reset-cleared pipeline would otherwise see a line that was already
   // high through reset as a fresh 0->1. Edges only count once both the last
   // sync stage and the delay flop hold post-reset samples.
   assign rise_o = arm_q[STAGES] ? (sync_q[STAGES-1] & ~dly_q) : '0;

endmodule

// File: rtl/req_pending_latch.sv
// Captures synchronized request edges into sticky pending bits and grants them one at a time.
// Latency: pend sets SYNC_STAGES+1 clocks after a request edge; grant_valid follows pend by 1 clock.
// Backpressure: grant_valid/grant_idx held until grant_ack; new edges keep latching meanwhile.
//
// Ports:
//   clk          in  1       clock
//   rst          in  1       asynchronous reset, active-high
//   req_in       in  4       raw async request lines, bit 3 highest priority
//   pend         out 4       pending bits, drive external priority encoder D3..D0
//   enc_idx      in  2       encoder index {x,y}
//   enc_valid    in  1       encoder any-valid z
//   grant_idx    out 2       index being served, frozen while grant_valid=1
//   grant_valid  out 1       grant offered
//   grant_ack    in  1       grant accepted (ignored while grant_valid=0)
//   drop_cnt     out DROP_W  saturating count of edges landing on an already-pending bit
module req_pending_latch
   import req_pending_latch_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,   // 2..3
   parameter int HOLDOFF_CYCLES = 1,   // 0..15
   parameter int DROP_W         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req_in,
   output logic [N_REQ-1:0]  pend,
   input  logic [IDX_W-1:0]  enc_idx,
   input  logic              enc_valid,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              grant_valid,
   input  logic              grant_ack,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int        HOLD_W    = 4;
   localparam logic [HOLD_W-1:0] HOLD_LOAD =
      HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

   logic [N_REQ-1:0]  rise;
   logic [N_REQ-1:0]  clr;
   logic [N_REQ-1:0]  pend_q,     pend_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              drop_hit;
   state_t            state_q;
   logic [IDX_W-1:0]  grant_idx_q;
   logic              grant_valid_q;
   logic [HOLD_W-1:0] hold_cnt_q;

   req_pending_latch_sync_edge #(
      .STAGES (SYNC_STAGES),
      .N      (N_REQ)
   ) u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req_in),
      .rise_o (rise)
   );

   // Only the ack cycle of an open grant clears anything.
   assign clr = (state_q == S_GRANT && grant_ack) ? idx_onehot(grant_idx_q) : '0;

   // A rise on a bit being cleared this cycle simply re-arms it; only a rise
   // on a bit that stays pending is a lost request.
   always_comb begin
      pend_d     = (pend_q & ~clr) | rise;
      drop_hit   = |(rise & pend_q & ~clr);
      drop_cnt_d = drop_cnt_q;
      if (drop_hit && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         hold_cnt_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enc_valid) begin
                  grant_idx_q   <= enc_idx;
                  grant_valid_q <= 1'b1;
                  state_q       <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (grant_ack) begin
                  grant_valid_q <= 1'b0;
                  if (HOLDOFF_CYCLES > 0) begin
                     hold_cnt_q <= HOLD_LOAD;
                     state_q    <= S_HOLD;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_HOLD: begin
               // Gives the external encoder time to settle on the cleared pend.
               if (hold_cnt_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
               end
            end
            default: begin
               grant_valid_q <= 1'b0;
               state_q       <= S_IDLE;
            end
         endcase
      end
   end

   assign pend        = pend_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign drop_cnt    = drop_cnt_q;

endmodule
